// File: rtl/rgb_pkg.sv
// Shared pixel/word datatypes for the RGB packing stage.
//   word_t          32-bit bus word, byte 0 at [7:0]
//   pixel_t         24-bit pixel {R[23:16], G[15:8], B[7:0]}
//   packer_state_e  packer FSM states
package rgb_pkg;

  localparam int unsigned PIX_BYTES  = 3;
  localparam int unsigned WORD_BYTES = 4;

  typedef bit [31:0] word_t;

  typedef struct packed {
    bit [7:0] r;
    bit [7:0] g;
    bit [7:0] b;
  } pixel_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } packer_state_e;

  // Stream order is R, G, B, so R lands in the lowest byte.
  function automatic logic [23:0] pixel_to_stream(pixel_t p);
    return {p.b, p.g, p.r};
  endfunction

endpackage

// File: rtl/rgb_word_out_reg.sv
// Output holding register for packed words. Contents stay stable while valid_o is high and
// ready_i is low; a load replaces the contents whenever the slot is free.
//   load_i/word_i/last_i/bytes_i  new word to hold (load_i only asserted when free_o)
//   ready_i                       downstream consumes the held word
//   free_o                        slot empty or being consumed this cycle
//   valid_o/word_o/last_o/bytes_o held word towards the consumer
module rgb_word_out_reg
  import rgb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  word_t       word_i,
  input  logic        last_i,
  input  logic [2:0]  bytes_i,
  input  logic        ready_i,
  output logic        free_o,
  output logic        valid_o,
  output word_t       word_o,
  output logic        last_o,
  output logic [2:0]  bytes_o
);

  logic       valid_q;
  word_t      word_q;
  logic       last_q;
  logic [2:0] bytes_q;

  assign free_o = !valid_q || ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      last_q  <= 1'b0;
      bytes_q <= 3'd0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      word_q  <= word_i;
      last_q  <= last_i;
      bytes_q <= bytes_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign word_o  = word_q;
  assign last_o  = last_q;
  assign bytes_o = bytes_q;

endmodule

// File: rtl/rgb_word_packer.sv
// Packs a stream of 24-bit RGB pixels densely into 32-bit words (4 pixels -> 3 words).
// in_last flushes any leftover bytes as a short final word.
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready/in_pixel/in_last   pixel input handshake
//   out_valid/out_ready/out_word/out_last/out_bytes  word output handshake
//   frame_words                     word count of the last completed frame (saturating)
module rgb_word_packer
  import rgb_pkg::*;
#(
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [23:0]            in_pixel,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_word,
  output logic                   out_last,
  output logic [2:0]             out_bytes,
  output logic [FRAME_CNT_W-1:0] frame_words
);

  packer_state_e state_q, state_d;
  logic [23:0]   res_q, res_d;       // leftover bytes, oldest at [7:0], unused bytes zero
  logic [1:0]    res_cnt_q, res_cnt_d;

  logic          slot_free;
  logic          accept;
  logic          load;
  word_t         load_word;
  logic          load_last;
  logic [2:0]    load_bytes;
  logic [55:0]   merged;
  logic [2:0]    total;
  word_t         held_word;

  assign in_ready = (state_q == RUN) && slot_free;
  assign accept   = in_valid && in_ready;

  // Residue followed by the new pixel's bytes; at most 6 valid bytes.
  assign merged = {32'd0, res_q}
                | ({32'd0, pixel_to_stream(pixel_t'(in_pixel))} << {res_cnt_q, 3'b000});
  assign total  = {1'b0, res_cnt_q} + 3'(PIX_BYTES);

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    res_cnt_d  = res_cnt_q;
    load       = 1'b0;
    load_word  = merged[31:0];
    load_last  = 1'b0;
    load_bytes = 3'(WORD_BYTES);
    unique case (state_q)
      RUN: begin
        if (accept) begin
          if (total >= 3'(WORD_BYTES)) begin
            load      = 1'b1;
            res_d     = merged[55:32];
            res_cnt_d = 2'(total - 3'(WORD_BYTES));
            if (in_last) begin
              if (total == 3'(WORD_BYTES)) load_last = 1'b1;
              else                         state_d   = FLUSH;
            end
          end else if (in_last) begin
            // Only reachable with an empty residue: single 3-byte last word.
            load       = 1'b1;
            load_last  = 1'b1;
            load_bytes = 3'(PIX_BYTES);
            res_d      = '0;
            res_cnt_d  = 2'd0;
          end else begin
            res_d     = merged[23:0];
            res_cnt_d = 2'(total);
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          load       = 1'b1;
          load_word  = {8'h00, res_q};
          load_last  = 1'b1;
          load_bytes = {1'b0, res_cnt_q};
          res_d      = '0;
          res_cnt_d  = 2'd0;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      res_q     <= '0;
      res_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  rgb_word_out_reg u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .word_i  (load_word),
    .last_i  (load_last),
    .bytes_i (load_bytes),
    .ready_i (out_ready),
    .free_o  (slot_free),
    .valid_o (out_valid),
    .word_o  (held_word),
    .last_o  (out_last),
    .bytes_o (out_bytes)
  );

  assign out_word = held_word;

  // Frame word counter.
  logic [FRAME_CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_words_q, frame_words_d;
  logic [FRAME_CNT_W-1:0] cnt_inc;

  assign cnt_inc = (&word_cnt_q) ? word_cnt_q : word_cnt_q + 1'b1;

  always_comb begin
    word_cnt_d    = word_cnt_q;
    frame_words_d = frame_words_q;
    if (out_valid && out_ready) begin
      if (out_last) begin
        frame_words_d = cnt_inc;
        word_cnt_d    = '0;
      end else begin
        word_cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q    <= '0;
      frame_words_q <= '0;
    end else begin
      word_cnt_q    <= word_cnt_d;
      frame_words_q <= frame_words_d;
    end
  end

  assign frame_words = frame_words_q;

endmodule
